pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard controller for the 5-stage RV64 pipeline: EX and ID-branch forwarding selects,
//  load-use and branch-operand stalls, taken-branch flush, whole-pipe freeze on a multi-cycle data memory.
//  Replaces the separate hazard/forward units; sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  The top-level CPU feeds it stage register addresses and control bits; it drives every stage enable/flush.
// PARAMETERS
//  REGW          5    register address width (x0 hard-wired zero, never forwarded/hazarded)
//  MEM_WAIT_MAX  15   max consecutive dmem wait cycles before timeout
//  CNT_W         32   width of performance counters
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous reset, active-low
//  id_rs1,id_rs2  in   REGW  source regs of instr in ID
//  id_use_rs1/2   in   1     ID instr actually reads rs1/rs2
//  id_is_branch   in   1     ID instr is a conditional branch (compared in ID)
//  branch_taken   in   1     ID comparator & PCSrc result
//  ex_rs1,ex_rs2  in   REGW  source regs in ID/EX
//  ex_rd          in   REGW  dest reg in ID/EX
//  ex_reg_write   in   1     ID/EX RegWrite
//  ex_mem_read    in   1     ID/EX MemRead
//  mem_rd         in   REGW  dest reg in EX/MEM
//  mem_reg_write  in   1     EX/MEM RegWrite
//  mem_mem_read   in   1     EX/MEM MemRead
//  wb_rd          in   REGW  dest reg in MEM/WB
//  wb_reg_write   in   1     MEM/WB RegWrite
//  dmem_req       in   1     MEM stage access (read or write) this cycle
//  dmem_ready     in   1     data memory completes access this cycle
//  pc_en,ifid_en  out  1     PC / IF-ID write enable
//  ifid_flush     out  1     zero IF/ID instruction
//  idex_bubble    out  1     force ID/EX control bits to 0
//  exmem_en       out  1     EX/MEM + ID/EX write enable (freeze when 0)
//  memwb_bubble   out  1     load zero control into MEM/WB
//  fwd_a,fwd_b    out  2     EX mux select: 00 regfile, 01 EX/MEM ALU, 10 WB data
//  fwd_id_a/b     out  1     ID comparator operand from EX/MEM ALU result
//  mem_timeout    out  1     sticky error, cleared only by reset
// BEHAVIOUR
//  match(r,s): r!=0 && r==s. Forwarding combinational; EX/MEM wins over MEM/WB for the same reg.
//  fwd_a=01 if mem_reg_write&&match(mem_rd,ex_rs1); else 10 if wb_reg_write&&match(wb_rd,ex_rs1); else 00. fwd_b same on ex_rs2.
//  fwd_id_x=1 if mem_reg_write&&!mem_mem_read&&match(mem_rd,id_rsx). No WB forward to ID (regfile writes on negedge).
//  load_use = ex_mem_read && ex_reg_write && (id_use_rs1&&match(ex_rd,id_rs1) || id_use_rs2&&match(ex_rd,id_rs2)).
//  br_stall = id_is_branch && ((ex_reg_write&&match ex_rd) || (mem_mem_read&&mem_reg_write&&match mem_rd)) on used rs.
//  stall = load_use|br_stall: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; lasts 1 cycle per hazard (load->branch = 2).
//  flush = branch_taken && !stall && !freeze: ifid_flush=1 (1-cycle penalty); branch_taken ignored while stalled.
//  FSM RUN/WAIT, state register reset to RUN. RUN: dmem_req&&!dmem_ready -> WAIT, wait_cnt<=1.
//  WAIT: dmem_ready -> RUN; else wait_cnt++; wait_cnt==MEM_WAIT_MAX -> mem_timeout<=1, RUN (access abandoned).
//  freeze = (RUN&&dmem_req&&!dmem_ready)||(WAIT&&!dmem_ready): pc_en=ifid_en=exmem_en=0, memwb_bubble=1, no flush/bubble.
//  Completion cycle (dmem_ready=1) is not frozen. Priority: freeze > stall > flush.
//  Reset (any cycle, incl. mid-WAIT): state RUN, wait_cnt 0, mem_timeout 0, counters 0; comb outputs then follow inputs
//  (idle inputs: pc_en=ifid_en=exmem_en=1, bubbles/flush 0, fwd 00).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt, flush_cnt, freeze_cnt [CNT_W], +1 per cycle of
//  stall/flush/freeze, saturate at all-ones, reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  ex: mem_rd=5,mem_reg_write=1,wb_rd=5,wb_reg_write=1,ex_rs1=5 -> fwd_a=01; mem_reg_write=0 -> fwd_a=10; rd=0 -> 00.
//  ld x3 in EX, ID add uses rs2=x3 -> 1 cycle pc_en=0,ifid_en=0,idex_bubble=1; next cycle all normal.
//  ld x4 in EX, ID beq on x4 -> 2 stall cycles, then fwd_id=0; branch_taken=1 -> ifid_flush=1 for exactly 1 cycle.
//  dmem_req=1,dmem_ready low 3 cycles -> freeze 3 cycles, memwb_bubble=1; ready on 4th -> pc_en=1, state RUN.
//  dmem_ready held 0 -> mem_timeout=1 after MEM_WAIT_MAX(15) cycles, stays 1; rst=0 mid-WAIT -> RUN, mem_timeout=0.
//  HAZARD_PERF_CNT_EN: 2 stalls+1 flush+3 freeze cycles -> stall_cnt=2, flush_cnt=1, freeze_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard controller for the 5-stage RV64 pipeline.
// Produces EX/ID forwarding selects, load-use and branch-operand stalls,
// taken-branch flush, and a whole-pipe freeze while a data memory access waits.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush/freeze counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REGW         = 5,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_is_branch,
  input  logic            branch_taken,
  input  logic [REGW-1:0] ex_rs1,
  input  logic [REGW-1:0] ex_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            exmem_en,
  output logic            memwb_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            fwd_id_a,
  output logic            fwd_id_b,
  output logic            mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam int unsigned WCNT_W = $clog2(MEM_WAIT_MAX + 1);

  // Elaboration-time guard on the counter width
  if (CNT_W == 0) begin : g_cnt_w_invalid
    $error("CNT_W must be nonzero");
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_d;
  logic              timeout_set;

  logic              load_use;
  logic              br_stall;
  logic              stall;
  logic              freeze;
  logic              flush;

  // x0 is hard-wired zero and never matches a producer
  function automatic logic match(input logic [REGW-1:0] r, input logic [REGW-1:0] s);
    return (r != '0) && (r == s);
  endfunction

  // EX operand forwarding; EX/MEM result is newer than MEM/WB so it wins
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && match(mem_rd, ex_rs1)) begin
      fwd_a = 2'b01;
    end else if (wb_reg_write && match(wb_rd, ex_rs1)) begin
      fwd_a = 2'b10;
    end
    if (mem_reg_write && match(mem_rd, ex_rs2)) begin
      fwd_b = 2'b01;
    end else if (wb_reg_write && match(wb_rd, ex_rs2)) begin
      fwd_b = 2'b10;
    end
  end

  // ID comparator forwarding from the EX/MEM ALU result (loads not yet available)
  always_comb begin
    fwd_id_a = mem_reg_write && !mem_mem_read && match(mem_rd, id_rs1);
    fwd_id_b = mem_reg_write && !mem_mem_read && match(mem_rd, id_rs2);
  end

  // Load-use and branch-operand hazard detection
  always_comb begin
    load_use = ex_mem_read && ex_reg_write &&
               ((id_use_rs1 && match(ex_rd, id_rs1)) ||
                (id_use_rs2 && match(ex_rd, id_rs2)));
    br_stall = id_is_branch &&
               ((id_use_rs1 && ((ex_reg_write && match(ex_rd, id_rs1)) ||
                                (mem_mem_read && mem_reg_write && match(mem_rd, id_rs1)))) ||
                (id_use_rs2 && ((ex_reg_write && match(ex_rd, id_rs2)) ||
                                (mem_mem_read && mem_reg_write && match(mem_rd, id_rs2)))));
    stall    = load_use || br_stall;
    freeze   = ((state_q == ST_RUN) && dmem_req && !dmem_ready) ||
               ((state_q == ST_WAIT) && !dmem_ready);
    flush    = branch_taken && !stall && !freeze;
  end

  // Memory-wait FSM state, wait counter and sticky timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_timeout <= mem_timeout || timeout_set;
    end
  end

  // Memory-wait FSM next state; a timed-out access is abandoned back to RUN
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(MEM_WAIT_MAX)) begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage enables/bubbles with priority freeze > stall > flush
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating per-cycle event counters; a stall hidden by a freeze is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && !freeze && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (freeze && (freeze_cnt != '1)) begin
        freeze_cnt <= freeze_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, id_is_branch, branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
  logic       dmem_req, dmem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       fwd_id_a, fwd_id_b, mem_timeout;
  logic [11:0] outv;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Output nibble map: {pc,ifid,flush,bubble}{exmem,memwb,fwd_a}{fwd_b,id_a,id_b}
  localparam logic [11:0] O_NORM   = 12'hC80;
  localparam logic [11:0] O_STALL  = 12'h180;
  localparam logic [11:0] O_FLUSH  = 12'hE80;
  localparam logic [11:0] O_FREEZE = 12'h040;

  pipeline_hazard_ctrl #(.REGW(5), .MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign outv = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble,
                 fwd_a, fwd_b, fwd_id_a, fwd_id_b};

  typedef struct {
    string      name;
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2, br, tk;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw, mem_mr;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t v(input string nm,
      input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
      input logic br, input logic tk,
      input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] ed,
      input logic erw, input logic emr,
      input logic [4:0] md, input logic mrw, input logic mmr,
      input logic [4:0] wd, input logic wrw, input logic [11:0] exp);
    vec_t r;
    r.name = nm; r.id_rs1 = a1; r.id_rs2 = a2; r.u1 = u1; r.u2 = u2; r.br = br; r.tk = tk;
    r.ex_rs1 = e1; r.ex_rs2 = e2; r.ex_rd = ed; r.ex_rw = erw; r.ex_mr = emr;
    r.mem_rd = md; r.mem_rw = mrw; r.mem_mr = mmr; r.wb_rd = wd; r.wb_rw = wrw; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_branch = 0; branch_taken = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = '0; mem_reg_write = 0; mem_mem_read = 0; wb_rd = '0; wb_reg_write = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic apply(input vec_t t);
    id_rs1 = t.id_rs1; id_rs2 = t.id_rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_is_branch = t.br; branch_taken = t.tk;
    ex_rs1 = t.ex_rs1; ex_rs2 = t.ex_rs2; ex_rd = t.ex_rd;
    ex_reg_write = t.ex_rw; ex_mem_read = t.ex_mr;
    mem_rd = t.mem_rd; mem_reg_write = t.mem_rw; mem_mem_read = t.mem_mr;
    wb_rd = t.wb_rd; wb_reg_write = t.wb_rw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //           name                 rs1 rs2 u1 u2 br tk exr1 exr2 exrd rw mr memrd rw mr wbrd rw exp
    vecs[0]  = v("idle",               0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, O_NORM);
    vecs[1]  = v("fwd_a_mem_wins",     0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 1, 0,  5, 1, 12'hC90);
    vecs[2]  = v("fwd_a_wb",           0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 0, 0,  5, 1, 12'hCA0);
    vecs[3]  = v("fwd_a_x0",           0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0,  0, 1, O_NORM);
    vecs[4]  = v("fwd_b_wb",           0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0,  0, 0, 0,  7, 1, 12'hC88);
    vecs[5]  = v("fwd_b_mem_wins",     0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0,  7, 1, 0,  7, 1, 12'hC84);
    vecs[6]  = v("fwd_ab_mem",         0, 0, 0, 0, 0, 0,  9, 9, 0, 0, 0,  9, 1, 0,  0, 0, 12'hC94);
    vecs[7]  = v("load_use_rs2",       0, 3, 0, 1, 0, 0,  0, 0, 3, 1, 1,  0, 0, 0,  0, 0, O_STALL);
    vecs[8]  = v("load_use_not_used",  0, 3, 0, 0, 0, 0,  0, 0, 3, 1, 1,  0, 0, 0,  0, 0, O_NORM);
    vecs[9]  = v("load_use_x0",        0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0,  0, 0, O_NORM);
    vecs[10] = v("br_ex_alu",          4, 0, 1, 0, 1, 0,  0, 0, 4, 1, 0,  0, 0, 0,  0, 0, O_STALL);
    vecs[11] = v("br_mem_load",        4, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  4, 1, 1,  0, 0, O_STALL);
    vecs[12] = v("br_fwd_id_b_taken",  0, 6, 0, 1, 1, 1,  0, 0, 0, 0, 0,  6, 1, 0,  0, 0, 12'hE81);
    vecs[13] = v("fwd_id_a",           6, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  6, 1, 0,  0, 0, 12'hC82);
    vecs[14] = v("taken_during_stall", 4, 0, 1, 0, 1, 1,  0, 0, 4, 1, 0,  0, 0, 0,  0, 0, O_STALL);
    vecs[15] = v("taken_plain",        0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, O_FLUSH);
    vecs[16] = v("ex_read_no_write",   3, 0, 1, 0, 0, 0,  0, 0, 3, 0, 1,  0, 0, 0,  0, 0, O_NORM);
    vecs[17] = v("no_write_no_fwd",    0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 0, 0,  5, 0, O_NORM);
    vecs[18] = v("br_rs2_not_used",    0, 4, 0, 0, 1, 0,  0, 0, 4, 1, 0,  0, 0, 0,  0, 0, O_NORM);

    // Reset state
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_outputs", 32'(outv), 32'(O_NORM));
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Combinational table
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outv), 32'(vecs[i].exp));
    end

    // Load then dependent branch: two stalls, then resolve and flush once
    @(negedge clk); clear_inputs();
    id_rs1 = 4; id_use_rs1 = 1; id_is_branch = 1; ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1;
    #1 chk("ldbr_stall1", 32'(outv), 32'(O_STALL));
    @(negedge clk);
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; mem_rd = 4; mem_reg_write = 1; mem_mem_read = 1;
    #1 chk("ldbr_stall2", 32'(outv), 32'(O_STALL));
    @(negedge clk);
    mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0; wb_rd = 4; wb_reg_write = 1; branch_taken = 1;
    #1 chk("ldbr_flush", 32'(outv), 32'(O_FLUSH));
    @(negedge clk); clear_inputs();
    #1 chk("ldbr_after", 32'(outv), 32'(O_NORM));

    // Freeze for 3 wait cycles with a pending stall and taken branch underneath
    @(negedge clk); clear_inputs();
    id_rs2 = 3; id_use_rs2 = 1; ex_rd = 3; ex_reg_write = 1; ex_mem_read = 1; branch_taken = 1;
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; dmem_req = 1; dmem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("freeze_cyc%0d", c), 32'(outv), 32'h050);
      @(negedge clk);
    end
    dmem_ready = 1;
    #1 chk("freeze_done_stall", 32'(outv), 32'h190);
    @(negedge clk); clear_inputs();
    #1 chk("freeze_after", 32'(outv), 32'(O_NORM));
    chk("freeze_no_timeout", 32'(mem_timeout), 32'd0);

    // Timeout: dmem_ready held low, sticky after dmem_req drops
    @(negedge clk); clear_inputs(); dmem_req = 1;
    repeat (5) @(negedge clk);
    #1 chk("wait5_timeout", 32'(mem_timeout), 32'd0);
    chk("wait5_freeze", 32'(outv), 32'(O_FREEZE));
    repeat (20) @(negedge clk);
    #1 chk("wait25_timeout", 32'(mem_timeout), 32'd1);
    dmem_req = 0;
    repeat (3) @(negedge clk);
    #1 chk("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of WAIT returns to RUN and clears timeout
    dmem_req = 1;
    repeat (3) @(negedge clk);
    dmem_req = 0;
    #1 chk("wait_no_req_frozen", 32'(outv), 32'(O_FREEZE));
    rst = 1'b0;
    #1 chk("midwait_rst_timeout", 32'(mem_timeout), 32'd0);
    chk("midwait_rst_outputs", 32'(outv), 32'(O_NORM));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_run", 32'(outv), 32'(O_NORM));

`ifdef HAZARD_PERF_CNT_EN
    // 2 stall + 1 flush + 3 freeze cycles
    do_reset();
    apply(vecs[7]);
    repeat (2) @(negedge clk);
    apply(vecs[15]);
    @(negedge clk); clear_inputs();
    dmem_req = 1;
    repeat (3) @(negedge clk);
    dmem_ready = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk);
    #1;
    chk("stall_cnt", stall_cnt, 32'd2);
    chk("flush_cnt", flush_cnt, 32'd1);
    chk("freeze_cnt", freeze_cnt, 32'd3);
`else
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
